// File: rtl/half_subtractor.sv
// One-bit half subtractor with a registered, valid-qualified result stage
// and saturating operation/borrow statistics counters.
module half_subtractor #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             in_valid,
  output logic             diff,
  output logic             br,
  output logic             diff_q,
  output logic             br_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] br_count
);

  typedef struct packed {
    logic diff;
    logic br;
  } res_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  res_t res_c, res_q;

  // Combinational path stays live through reset and ignores in_valid.
  assign res_c.diff = a ^ b;
  assign res_c.br   = ~a & b;
  assign diff       = res_c.diff;
  assign br         = res_c.br;
  assign diff_q     = res_q.diff;
  assign br_q       = res_q.br;

  // Everything is gated by in_valid, so a/b are don't-care while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q     <= '0;
      out_valid <= 1'b0;
      op_count  <= '0;
      br_count  <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        res_q <= res_c;
        if (op_count != CNT_MAX)
          op_count <= op_count + CNT_ONE;
        if (res_c.br && (br_count != CNT_MAX))
          br_count <= br_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_half_subtractor.sv
// Directed-vector bench for half_subtractor: truth table, pipeline, gap,
// counter saturation (CNT_W=2 instance) and asynchronous mid-stream reset.
module tb_half_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       a, b, in_valid;
  logic       diff, br, diff_q, br_q, out_valid;
  logic [7:0] op_count, br_count;

  logic       s_a, s_b, s_iv;
  logic       s_diff, s_br, s_diff_q, s_br_q, s_out_valid;
  logic [1:0] s_op_count, s_br_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  half_subtractor #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid),
    .diff(diff), .br(br), .diff_q(diff_q), .br_q(br_q),
    .out_valid(out_valid), .op_count(op_count), .br_count(br_count)
  );

  half_subtractor #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .a(s_a), .b(s_b), .in_valid(s_iv),
    .diff(s_diff), .br(s_br), .diff_q(s_diff_q), .br_q(s_br_q),
    .out_valid(s_out_valid), .op_count(s_op_count), .br_count(s_br_count)
  );

  typedef struct {
    logic       a, b, iv;
    logic       d, bo;
    logic       dq, bq, ov;
    logic [7:0] opc, brc;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic ia, logic ib, logic iv, logic d, logic bo,
                              logic dq, logic bq, logic ov, logic [7:0] opc, logic [7:0] brc);
    vec_t v;
    v.a = ia; v.b = ib; v.iv = iv; v.d = d; v.bo = bo;
    v.dq = dq; v.bq = bq; v.ov = ov; v.opc = opc; v.brc = brc;
    return v;
  endfunction

  initial begin
    //            a   b   iv  diff br  dq  bq  ov  op br
    tbl[0]  = mk(0,  0,  0,  0,  0,  0,  0,  0,  0, 0);
    tbl[1]  = mk(1,  0,  0,  1,  0,  0,  0,  0,  0, 0);
    tbl[2]  = mk(0,  1,  0,  1,  1,  0,  0,  0,  0, 0);
    tbl[3]  = mk(1,  1,  0,  0,  0,  0,  0,  0,  0, 0);
    tbl[4]  = mk(0,  0,  1,  0,  0,  0,  0,  1,  1, 0);
    tbl[5]  = mk(1,  0,  1,  1,  0,  1,  0,  1,  2, 0);
    tbl[6]  = mk(0,  1,  1,  1,  1,  1,  1,  1,  3, 1);
    tbl[7]  = mk(1,  1,  1,  0,  0,  0,  0,  1,  4, 1);
    tbl[8]  = mk(0,  1,  1,  1,  1,  1,  1,  1,  5, 2);
    tbl[9]  = mk(1,  1,  0,  0,  0,  1,  1,  0,  5, 2);
    tbl[10] = mk(0,  0,  0,  0,  0,  1,  1,  0,  5, 2);

    rst = 1'b1; a = 1'b0; b = 1'b0; in_valid = 1'b0;
    s_a = 1'b0; s_b = 1'b0; s_iv = 1'b0;

    // Reset state before any clock edge.
    #1;
    check("rst_diff_q", diff_q, 0);
    check("rst_br_q", br_q, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_op_count", op_count, 0);
    check("rst_br_count", br_count, 0);

    // An in_valid edge during reset must not be accepted.
    in_valid = 1'b1; a = 1'b0; b = 1'b1;
    @(posedge clk); #1;
    check("rst_edge_op_count", op_count, 0);
    check("rst_edge_out_valid", out_valid, 0);
    check("rst_comb_diff", diff, 1);
    check("rst_comb_br", br, 1);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      a = tbl[i].a; b = tbl[i].b; in_valid = tbl[i].iv;
      #1;
      check($sformatf("v%0d_diff", i), diff, tbl[i].d);
      check($sformatf("v%0d_br", i), br, tbl[i].bo);
      @(posedge clk); #1;
      check($sformatf("v%0d_diff_q", i), diff_q, tbl[i].dq);
      check($sformatf("v%0d_br_q", i), br_q, tbl[i].bq);
      check($sformatf("v%0d_out_valid", i), out_valid, tbl[i].ov);
      check($sformatf("v%0d_op_count", i), op_count, tbl[i].opc);
      check($sformatf("v%0d_br_count", i), br_count, tbl[i].brc);
    end
    @(negedge clk);
    in_valid = 1'b0;

    // Saturation on the 2-bit counter instance: six borrowing ops.
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      s_a = 1'b0; s_b = 1'b1; s_iv = 1'b1;
      @(posedge clk); #1;
      check($sformatf("sat%0d_op_count", i), s_op_count, (i > 3) ? 3 : i);
      check($sformatf("sat%0d_br_count", i), s_br_count, (i > 3) ? 3 : i);
    end
    @(negedge clk);
    s_a = 1'b1; s_b = 1'b1;
    @(posedge clk); #1;
    check("sat_hold_op_count", s_op_count, 3);
    check("sat_hold_br_count", s_br_count, 3);
    check("sat_diff_q", s_diff_q, 0);

    // Asynchronous reset between edges while a stream is running.
    @(negedge clk);
    a = 1'b0; b = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    check("pre_rst_out_valid", out_valid, 1);
    check("pre_rst_op_count", op_count, 6);
    #2;
    rst = 1'b1;
    #1;
    check("async_diff_q", diff_q, 0);
    check("async_br_q", br_q, 0);
    check("async_out_valid", out_valid, 0);
    check("async_op_count", op_count, 0);
    check("async_br_count", br_count, 0);
    check("async_sat_op_count", s_op_count, 0);
    check("async_sat_out_valid", s_out_valid, 0);
    a = 1'b1; b = 1'b0;
    #1;
    check("async_comb_diff", diff, 1);
    check("async_comb_br", br, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rel_out_valid", out_valid, 0);
    check("post_rel_op_count", op_count, 0);
    @(posedge clk); #1;
    check("post_rel_op1_count", op_count, 1);
    check("post_rel_br_count", br_count, 0);
    check("post_rel_diff_q", diff_q, 1);
    check("post_rel_out_valid1", out_valid, 1);
    @(negedge clk);
    in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/half_subtractor.md
HALF_SUBTRACTOR -- requirements
Module: half_subtractor

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 Parameter CNT_W, default 8, SHALL set the width of both statistics counters (legal range 2..32).
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 Port rst, input, 1, SHALL be the asynchronous active-high reset.
REQ-005 Port a, input, 1, SHALL be the minuend bit.
REQ-006 Port b, input, 1, SHALL be the subtrahend bit.
REQ-007 Port in_valid, input, 1, SHALL qualify a/b; an operation is accepted on a rising clk edge with in_valid=1 and rst=0.
REQ-008 Port diff, output, 1, SHALL be the combinational difference of a-b.
REQ-009 Port br, output, 1, SHALL be the combinational borrow of a-b.
REQ-010 Port diff_q, output, 1, SHALL be the registered difference of the last accepted operation.
REQ-011 Port br_q, output, 1, SHALL be the registered borrow of the last accepted operation.
REQ-012 Port out_valid, output, 1, SHALL pulse high for one cycle after each accepted operation.
REQ-013 Port op_count, output, CNT_W, SHALL count accepted operations.
REQ-014 Port br_count, output, CNT_W, SHALL count accepted operations that produced br=1.

Function
REQ-015 diff SHALL equal a XOR b at all times, with zero cycles of latency, independent of clk, rst and in_valid.
REQ-016 br SHALL equal (NOT a) AND b at all times, with zero cycles of latency, independent of clk, rst and in_valid.
REQ-017 Truth table (a,b -> diff,br): 0,0->0,0; 1,0->1,0; 0,1->1,1; 1,1->0,0.
REQ-018 On an accepted operation, diff_q/br_q SHALL load the REQ-015/016 values of that edge's a/b (latency 1 cycle).
REQ-019 When in_valid=0 at an edge, diff_q/br_q SHALL hold their previous values.
REQ-020 out_valid SHALL be the registered copy of in_valid; it SHALL be high in the cycle following each accepted edge, and low otherwise.
REQ-021 Continuous in_valid=1 SHALL produce one result per cycle with out_valid held high; there is no backpressure.
REQ-022 op_count SHALL increment by 1 per accepted operation and saturate at 2^CNT_W-1 (no wrap).
REQ-023 br_count SHALL increment by 1 per accepted operation with borrow, and saturate at 2^CNT_W-1.
REQ-024 br_count SHALL never exceed op_count.
REQ-025 X/Z on a or b while in_valid=0 SHALL NOT affect any registered output.

Reset
REQ-026 While rst=1, diff_q=0, br_q=0, out_valid=0, op_count=0 and br_count=0 SHALL hold immediately, without waiting for a clk edge.
REQ-027 diff and br SHALL remain purely combinational and SHALL follow a/b during reset.
REQ-028 An edge with in_valid=1 while rst=1 SHALL NOT be accepted.
REQ-029 Reset asserted mid-stream SHALL discard any in-flight result; out_valid SHALL be 0 in the first cycle after rst is released.

Verification
REQ-030 After reset, apply a,b = 00, 10, 01, 11 for 10 ns each, in_valid=0 -> diff,br = 00, 10, 11, 00; registered outputs stay 0.
REQ-031 Same four vectors with in_valid=1 on consecutive edges -> diff_q/br_q one cycle later = 00, 10, 11, 00; out_valid high 4 cycles; op_count=4; br_count=1.
REQ-032 Gap test: accept 01, then in_valid=0 for 3 cycles -> diff_q=1 and br_q=1 held; out_valid low during the gap; counts unchanged.
REQ-033 Saturation with CNT_W=2: accept 01 six times -> op_count=3 and br_count=3, holding at 3.
REQ-034 Assert rst asynchronously between edges mid-stream -> all registered outputs 0 immediately; diff/br still track a/b; after release, the next accepted op yields op_count=1.
